line_buffer_2row: RTL and testbench

Raster-order line buffer that feeds the 3x3 window stage. Takes one pixel per accepted cycle and stores the two previous image rows in on-chip memories. Emits three vertically aligned taps (pix_curr, pix_m1, pix_m2) with a valid strobe, matching the window stage's in_valid/pix_curr/pix_m1/pix_m2 inputs. Tracks column and row position, and flags the end of each frame.

---
 rtl/line_buffer_2row_if.sv | 72 +++++++
 rtl/line_buffer_2row.sv | 191 +++++++++++++++++++
 tb/tb_line_buffer_2row.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/line_buffer_2row_if.sv
// ---------------------------------------------------------------------------
// line_buffer_2row_if
//
// Pixel stream bundle between a raster source and the two-row line buffer,
// and onward to the 3x3 window stage.
//
// Parameters:
//   DATA_WIDTH - pixel width in bits
//   WIDTH      - pixels per row
//   HEIGHT     - rows per frame
//
// Signals:
//   in_valid  - pix_in is presented and accepted this cycle
//   sof       - start of frame, qualified by in_valid
//   pix_in    - incoming raster pixel
//   out_valid - taps below are valid (window stage in_valid)
//   pix_curr  - pixel at (row y,   col x)
//   pix_m1    - pixel at (row y-1, col x)
//   pix_m2    - pixel at (row y-2, col x)
//   col_cnt   - column x of the current taps
//   row_cnt   - row y of the current taps
//   eof       - one-cycle pulse with the taps of the last pixel of a frame
//
// Modports:
//   master - pixel source side (drives in_valid/sof/pix_in)
//   slave  - line buffer side (drives taps and position)
// ---------------------------------------------------------------------------
interface line_buffer_2row_if #(
    parameter int DATA_WIDTH = 8,
    parameter int WIDTH      = 640,
    parameter int HEIGHT     = 480
);
    localparam int COL_W = $clog2(WIDTH);
    localparam int ROW_W = $clog2(HEIGHT);

    logic                  in_valid;
    logic                  sof;
    logic [DATA_WIDTH-1:0] pix_in;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] pix_curr;
    logic [DATA_WIDTH-1:0] pix_m1;
    logic [DATA_WIDTH-1:0] pix_m2;
    logic [COL_W-1:0]      col_cnt;
    logic [ROW_W-1:0]      row_cnt;
    logic                  eof;

    modport master (
        output in_valid,
        output sof,
        output pix_in,
        input  out_valid,
        input  pix_curr,
        input  pix_m1,
        input  pix_m2,
        input  col_cnt,
        input  row_cnt,
        input  eof
    );

    modport slave (
        input  in_valid,
        input  sof,
        input  pix_in,
        output out_valid,
        output pix_curr,
        output pix_m1,
        output pix_m2,
        output col_cnt,
        output row_cnt,
        output eof
    );
endinterface

// File: rtl/line_buffer_2row.sv
// ---------------------------------------------------------------------------
// line_buffer_2row
//
// Raster-order line buffer feeding a 3x3 window stage. Each accepted pixel
// produces, one cycle later, three vertically aligned taps: the pixel itself
// and the pixels in the same column of the two previous rows. Two WIDTH-deep
// memories hold row y-1 (lb1) and row y-2 (lb2). Column/row position of the
// taps is reported, and eof pulses with the last pixel of the frame.
//
// Ports:
//   clk    - single clock, rising edge
//   rst_n  - asynchronous active-low reset (memory contents are kept)
//   lb_if  - line_buffer_2row_if.slave: in_valid/sof/pix_in in,
//            out_valid/pix_curr/pix_m1/pix_m2/col_cnt/row_cnt/eof out
//
// Build option:
//   LB_ZERO_PAD_EN - when defined, every row produces out_valid and the taps
//                    above the top edge read as zero (pix_m1 on row 0,
//                    pix_m2 on rows 0 and 1). When undefined, rows 0 and 1
//                    only fill the memories and produce no output.
//
// No back-pressure: the consumer must take every out_valid cycle.
// ---------------------------------------------------------------------------
module line_buffer_2row #(
    parameter int DATA_WIDTH = 8,
    parameter int WIDTH      = 640,
    parameter int HEIGHT     = 480
) (
    input logic              clk,
    input logic              rst_n,
    line_buffer_2row_if.slave lb_if
);
    localparam int COL_W = $clog2(WIDTH);
    localparam int ROW_W = $clog2(HEIGHT);

    // ---------------------------------------------------------------------
    // Write pointer and effective position of the incoming pixel
    // ---------------------------------------------------------------------
    logic             acc;
    logic [COL_W-1:0] wr_col_q, wr_col_d;
    logic [ROW_W-1:0] wr_row_q, wr_row_d;
    logic [COL_W-1:0] eff_col;
    logic [ROW_W-1:0] eff_row;
    logic             col_last;
    logic             row_last;

    assign acc = lb_if.in_valid;

    always_comb begin
        // sof overrides the running pointer: the pixel becomes (0,0) and
        // counting resumes from there.
        eff_col  = lb_if.sof ? '0 : wr_col_q;
        eff_row  = lb_if.sof ? '0 : wr_row_q;
        col_last = (eff_col == COL_W'(WIDTH - 1));
        row_last = (eff_row == ROW_W'(HEIGHT - 1));

        wr_col_d = wr_col_q;
        wr_row_d = wr_row_q;
        if (acc) begin
            wr_row_d = eff_row;
            if (col_last) begin
                wr_col_d = '0;
                wr_row_d = row_last ? '0 : eff_row + ROW_W'(1);
            end else begin
                wr_col_d = eff_col + COL_W'(1);
            end
        end
    end

    // ---------------------------------------------------------------------
    // Output qualification
    // ---------------------------------------------------------------------
    logic out_valid_d;
    logic eof_d;
    logic m1_keep_d;
    logic m2_keep_d;

`ifdef LB_ZERO_PAD_EN
    // Every row is emitted; taps that would reach above the frame are zero.
    assign out_valid_d = acc;
    assign m1_keep_d   = (eff_row != '0);
    assign m2_keep_d   = (eff_row >= ROW_W'(2));
`else
    // Rows 0 and 1 only prime the memories.
    assign out_valid_d = acc && (eff_row >= ROW_W'(2));
    assign m1_keep_d   = 1'b1;
    assign m2_keep_d   = 1'b1;
`endif

    assign eof_d = acc && col_last && row_last;

    // ---------------------------------------------------------------------
    // Line memories
    //
    // lb1 is read and written at the same address on the accepting edge;
    // the registered read returns the old word (read-before-write).
    //
    // lb2 must receive the old lb1 word at that address. That word only
    // exists in lb1_rd_q after the edge, so the lb2 write is deferred by one
    // cycle. The only read that can collide with the deferred write is an
    // accept at the same column on the very next cycle (sof right after a
    // column-0 pixel); that read is forwarded from lb1_rd_q.
    // ---------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] lb1_mem [WIDTH];
    logic [DATA_WIDTH-1:0] lb2_mem [WIDTH];
    logic [DATA_WIDTH-1:0] lb1_rd_q;
    logic [DATA_WIDTH-1:0] lb2_rd_q;
    logic                  wb_pend_q;
    logic [COL_W-1:0]      wb_addr_q;
    logic                  wb_hit;

    assign wb_hit = wb_pend_q && (wb_addr_q == eff_col);

    always_ff @(posedge clk) begin
        if (acc) begin
            lb1_mem[eff_col] <= lb_if.pix_in;
            lb1_rd_q         <= lb1_mem[eff_col];
        end
    end

    always_ff @(posedge clk) begin
        if (wb_pend_q) begin
            lb2_mem[wb_addr_q] <= lb1_rd_q;
        end
        if (acc) begin
            lb2_rd_q <= wb_hit ? lb1_rd_q : lb2_mem[eff_col];
        end
    end

    // Deferred-write bookkeeping lives with the memories and has no reset:
    // a write lost to reset only touches rows that the next frame rewrites
    // before they are ever presented.
    always_ff @(posedge clk) begin
        wb_pend_q <= acc;
        if (acc) begin
            wb_addr_q <= eff_col;
        end
    end

    // ---------------------------------------------------------------------
    // Control and tap registers
    // ---------------------------------------------------------------------
    logic                  out_valid_q;
    logic                  eof_q;
    logic [DATA_WIDTH-1:0] pix_curr_q;
    logic [COL_W-1:0]      col_cnt_q;
    logic [ROW_W-1:0]      row_cnt_q;
    // The memory read registers are not reset; these enables zero the
    // m1/m2 taps after reset and implement top-edge padding.
    logic                  m1_keep_q;
    logic                  m2_keep_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_col_q    <= '0;
            wr_row_q    <= '0;
            out_valid_q <= 1'b0;
            eof_q       <= 1'b0;
            pix_curr_q  <= '0;
            col_cnt_q   <= '0;
            row_cnt_q   <= '0;
            m1_keep_q   <= 1'b0;
            m2_keep_q   <= 1'b0;
        end else begin
            wr_col_q    <= wr_col_d;
            wr_row_q    <= wr_row_d;
            out_valid_q <= out_valid_d;
            eof_q       <= eof_d;
            // Taps and position hold across stalls.
            if (acc) begin
                pix_curr_q <= lb_if.pix_in;
                col_cnt_q  <= eff_col;
                row_cnt_q  <= eff_row;
                m1_keep_q  <= m1_keep_d;
                m2_keep_q  <= m2_keep_d;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign lb_if.out_valid = out_valid_q;
    assign lb_if.eof       = eof_q;
    assign lb_if.pix_curr  = pix_curr_q;
    assign lb_if.pix_m1    = m1_keep_q ? lb1_rd_q : '0;
    assign lb_if.pix_m2    = m2_keep_q ? lb2_rd_q : '0;
    assign lb_if.col_cnt   = col_cnt_q;
    assign lb_if.row_cnt   = row_cnt_q;

endmodule

// File: tb/tb_line_buffer_2row.sv
// ---------------------------------------------------------------------------
// tb_line_buffer_2row
//
// Directed bench for line_buffer_2row with a 4x4 frame. Pixel values are
// frame_base + row*4 + col + 1 so every tap's expected value follows from
// the pixel's own value: pix_m1 = value-4, pix_m2 = value-8 within a frame.
// Covers fill, stall/hold, frame wrap, asynchronous reset mid-frame, sof
// resync, and (when LB_ZERO_PAD_EN is defined) top-edge zero padding.
// ---------------------------------------------------------------------------
module tb_line_buffer_2row;
    localparam int DW = 8;
    localparam int W  = 4;
    localparam int H  = 4;

`ifdef LB_ZERO_PAD_EN
    localparam bit ZP = 1'b1;
`else
    localparam bit ZP = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    line_buffer_2row_if #(.DATA_WIDTH(DW), .WIDTH(W), .HEIGHT(H)) lb_if ();

    line_buffer_2row #(.DATA_WIDTH(DW), .WIDTH(W), .HEIGHT(H)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .lb_if (lb_if)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Present one cycle of input on the falling edge, then return 1 ns after
    // the rising edge so outputs can be sampled.
    task automatic drive(input bit v, input int val, input bit s);
        logic [31:0] tmp;
        tmp = val;
        @(negedge clk);
        lb_if.in_valid = v;
        lb_if.pix_in   = tmp[DW-1:0];
        lb_if.sof      = s;
        @(posedge clk);
        #1;
    endtask

    // Send one pixel located at (r,c) and check all outputs one cycle later.
    task automatic pix(input int val, input int r, input int c, input bit s);
        bit ov_e;
        ov_e = ZP || (r >= 2);
        drive(1'b1, val, s);
        chk($sformatf("out_valid@%0d", val), {31'd0, lb_if.out_valid}, {31'd0, ov_e});
        chk($sformatf("eof@%0d", val), {31'd0, lb_if.eof}, (r == H-1 && c == W-1) ? 32'd1 : 32'd0);
        chk($sformatf("col@%0d", val), {30'd0, lb_if.col_cnt}, c);
        chk($sformatf("row@%0d", val), {30'd0, lb_if.row_cnt}, r);
        if (ov_e) begin
            chk($sformatf("curr@%0d", val), {24'd0, lb_if.pix_curr}, val);
            chk($sformatf("m1@%0d", val), {24'd0, lb_if.pix_m1}, (r >= 1) ? val - 4 : 0);
            chk($sformatf("m2@%0d", val), {24'd0, lb_if.pix_m2}, (r >= 2) ? val - 8 : 0);
        end
    endtask

    // Send an aligned range of pixels of one frame (values base+idx+1).
    task automatic pix_range(input int base, input int first_idx, input int last_idx);
        for (int i = first_idx; i <= last_idx; i++) begin
            pix(base + i + 1, i / W, i % W, 1'b0);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".out_valid"}, {31'd0, lb_if.out_valid}, 0);
        chk({tag, ".eof"},       {31'd0, lb_if.eof}, 0);
        chk({tag, ".curr"},      {24'd0, lb_if.pix_curr}, 0);
        chk({tag, ".m1"},        {24'd0, lb_if.pix_m1}, 0);
        chk({tag, ".m2"},        {24'd0, lb_if.pix_m2}, 0);
        chk({tag, ".col"},       {30'd0, lb_if.col_cnt}, 0);
        chk({tag, ".row"},       {30'd0, lb_if.row_cnt}, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        lb_if.in_valid = 1'b0;
        lb_if.sof      = 1'b0;
        lb_if.pix_in   = '0;

        // Reset state
        #2;
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Frame 1: fill rows 0-1, then rows 2-3 with a stall after pixel 10
        pix_range(0, 0, 9);          // pixel 9 -> (9,5,1) col0 row2
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 0, 1'b0);
            chk($sformatf("stall%0d.ov", k),  {31'd0, lb_if.out_valid}, 0);
            chk($sformatf("stall%0d.eof", k), {31'd0, lb_if.eof}, 0);
            chk($sformatf("stall%0d.curr", k), {24'd0, lb_if.pix_curr}, 10);
            chk($sformatf("stall%0d.m1", k),  {24'd0, lb_if.pix_m1}, 6);
            chk($sformatf("stall%0d.m2", k),  {24'd0, lb_if.pix_m2}, 2);
            chk($sformatf("stall%0d.col", k), {30'd0, lb_if.col_cnt}, 1);
            chk($sformatf("stall%0d.row", k), {30'd0, lb_if.row_cnt}, 2);
        end
        pix_range(0, 10, 15);        // pixel 11 -> (11,7,3) col2; 16 -> eof

        // Frame 2: row counter wrapped; old frame data must shift out
        pix_range(100, 0, 15);       // pixel 109 -> (109,105,101)

        // Reset in the middle of row 2
        pix_range(150, 0, 8);
        @(negedge clk);
        lb_if.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_all_zero("midrst");
        @(negedge clk);
        rst_n = 1'b1;

        // Fresh frame after reset starts at row 0, col 0
        pix_range(200, 0, 15);

        // sof resync on the 3rd pixel of row 1
        pix_range(230, 0, 5);
        pix(237, 0, 0, 1'b1);
        for (int i = 1; i < W*H; i++) begin
            pix(237 + i, i / W, i % W, 1'b0);
        end

        drive(1'b0, 0, 1'b0);
        chk("idle.ov", {31'd0, lb_if.out_valid}, 0);
        chk("idle.eof", {31'd0, lb_if.eof}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
